uart_rx: RTL



---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default oversampling constants.
// Imported by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int MID_SAMPLE         = OVERSAMPLE_DEFAULT/2 - 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is parameterised.
// Latency 2 clk, no backpressure.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, centre-sampled, LSB first, optional parity, one-clk valid pulse.
// Latency ~0.5 bit after stop-bit start (2 clk sync + 1 clk); no backpressure, outputs overwritten.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick_rx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);
    localparam logic             HAS_PAR   = (PARITY_EN != 0);

    logic                 rx_s;
    uart_rx_state_e       state_q, state_d;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d;
    logic                 rx_prev_q, rx_prev_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            rx_prev_q    <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            rx_prev_q    <= rx_prev_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        rx_prev_d    = rx_prev_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (baud_tick_rx) begin
            unique case (state_q)
                IDLE: begin
                    // Only a high-to-low transition opens a frame, so a held-low line stays quiet.
                    rx_prev_d = rx_s;
                    if (rx_prev_q && !rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = HAS_PAR ? PARITY : STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        perr_d     = (^shift_q) ^ rx_s ^ ODD;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d   = '0;
                        rx_data_d    = shift_q;
                        parity_err_d = HAS_PAR & perr_q;
                        frame_err_d  = ~rx_s;
                        rx_valid_d   = 1'b1;
                        rx_prev_d    = rx_s;
                        state_d      = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule
